// File: rtl/sort_pkg.sv
// Shared types for the sort host: controller state encoding and res_err bit positions.
package sort_pkg;

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_SHORT   = 1;
  localparam int ERR_ORDER   = 2;
  localparam int ERR_W       = 3;

endpackage

// File: rtl/sort_host_if.sv
// Sorter-facing job interface: start pulse and packed job out, serial sorted stream back.
interface sort_host_if #(
  parameter int DATA_N = 4,
  parameter int DATA_W = 4
);

  logic                       sort_start;
  logic [DATA_N*DATA_W-1:0]   sort_data;
  logic                       sort_out_vld;
  logic [DATA_W-1:0]          sort_out_data;

  modport master (
    output sort_start,
    output sort_data,
    input  sort_out_vld,
    input  sort_out_data
  );

  modport slave (
    input  sort_start,
    input  sort_data,
    output sort_out_vld,
    output sort_out_data
  );

endinterface

// File: rtl/sort_host.sv
// Host controller for the bubble sorter: packs a serial job, pulses start,
// gathers the sorted stream and reports the result with error flags.
module sort_host
  import sort_pkg::*;
#(
  parameter int DATA_N      = 4,
  parameter int DATA_W      = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_rdy,
  sort_host_if.master               sif,
  output logic                      res_vld,
  output logic [DATA_N*DATA_W-1:0]  res_data,
  output logic [ERR_W-1:0]          res_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DATA_N) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int VEC_W = DATA_N * DATA_W;

  state_t              state_r;
  logic [CNT_W-1:0]    load_cnt_r;
  logic [CNT_W-1:0]    coll_cnt_r;
  logic [TMO_W-1:0]    tmo_cnt_r;
  logic [VEC_W-1:0]    sort_data_r;
  logic [VEC_W-1:0]    buf_r;
  logic [DATA_W-1:0]   prev_r;
  logic [ERR_W-1:0]    err_r;
  logic                in_rdy_r;
  logic                busy_r;
  logic                sort_start_r;
  logic                res_vld_r;
  logic [VEC_W-1:0]    res_data_r;
  logic [ERR_W-1:0]    res_err_r;

  logic [VEC_W-1:0]    buf_nxt_s;
  logic [ERR_W-1:0]    err_nxt_s;

  // Result buffer and error flags as they would look after this cycle's sorter sample.
  always_comb begin
    buf_nxt_s = buf_r;
    err_nxt_s = err_r;
    if (sif.sort_out_vld) begin
      buf_nxt_s[int'(coll_cnt_r)*DATA_W +: DATA_W] = sif.sort_out_data;
      if ((state_r == COLLECT) && (sif.sort_out_data < prev_r)) begin
        err_nxt_s[ERR_ORDER] = 1'b1;
      end else begin
        err_nxt_s[ERR_ORDER] = err_r[ERR_ORDER];
      end
    end else begin
      if (state_r == COLLECT) begin
        err_nxt_s[ERR_SHORT] = 1'b1;
      end else if (state_r == WAIT) begin
        err_nxt_s[ERR_TIMEOUT] = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end
  end

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= LOAD;
      load_cnt_r   <= '0;
      coll_cnt_r   <= '0;
      tmo_cnt_r    <= '0;
      sort_data_r  <= '0;
      buf_r        <= '0;
      prev_r       <= '0;
      err_r        <= '0;
      in_rdy_r     <= 1'b1;
      busy_r       <= 1'b0;
      sort_start_r <= 1'b0;
      res_vld_r    <= 1'b0;
      res_data_r   <= '0;
      res_err_r    <= '0;
    end else begin
      case (state_r)
        LOAD: begin
          if (in_vld) begin
            sort_data_r[int'(load_cnt_r)*DATA_W +: DATA_W] <= in_data;
            if (load_cnt_r == CNT_W'(DATA_N - 1)) begin
              load_cnt_r   <= '0;
              state_r      <= START;
              in_rdy_r     <= 1'b0;
              busy_r       <= 1'b1;
              sort_start_r <= 1'b1;
            end else begin
              load_cnt_r <= load_cnt_r + CNT_W'(1);
            end
          end
        end
        START: begin
          sort_start_r <= 1'b0;
          buf_r        <= '0;
          err_r        <= '0;
          coll_cnt_r   <= '0;
          tmo_cnt_r    <= '0;
          state_r      <= WAIT;
        end
        WAIT: begin
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          if (sif.sort_out_vld) begin
            buf_r      <= buf_nxt_s;
            prev_r     <= sif.sort_out_data;
            coll_cnt_r <= CNT_W'(1);
            state_r    <= COLLECT;
          end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 2)) begin
            // Leaving here makes res_vld land exactly TIMEOUT_CYC cycles after start.
            err_r      <= err_nxt_s;
            res_data_r <= buf_r;
            res_err_r  <= err_nxt_s;
            res_vld_r  <= 1'b1;
            state_r    <= DONE;
          end
        end
        COLLECT: begin
          if (sif.sort_out_vld) begin
            buf_r  <= buf_nxt_s;
            prev_r <= sif.sort_out_data;
            err_r  <= err_nxt_s;
            if (coll_cnt_r == CNT_W'(DATA_N - 1)) begin
              res_data_r <= buf_nxt_s;
              res_err_r  <= err_nxt_s;
              res_vld_r  <= 1'b1;
              state_r    <= DONE;
            end else begin
              coll_cnt_r <= coll_cnt_r + CNT_W'(1);
            end
          end else begin
            err_r      <= err_nxt_s;
            res_data_r <= buf_r;
            res_err_r  <= err_nxt_s;
            res_vld_r  <= 1'b1;
            state_r    <= DONE;
          end
        end
        DONE: begin
          res_vld_r  <= 1'b0;
          coll_cnt_r <= '0;
          in_rdy_r   <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= LOAD;
        end
        default: begin
          state_r      <= LOAD;
          load_cnt_r   <= '0;
          coll_cnt_r   <= '0;
          in_rdy_r     <= 1'b1;
          busy_r       <= 1'b0;
          sort_start_r <= 1'b0;
          res_vld_r    <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy         = in_rdy_r;
  assign busy           = busy_r;
  assign sif.sort_start = sort_start_r;
  assign sif.sort_data  = sort_data_r;
  assign res_vld        = res_vld_r;
  assign res_data       = res_data_r;
  assign res_err        = res_err_r;

endmodule

// File: tb/tb_sort_host.sv
// Directed bench for sort_host: a queue-based job model checked every cycle,
// plus literal expectations on the result of each test job.
module tb_sort_host;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int T   = 8;
  localparam int BIG = 1000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic [W-1:0]  in_data;
  logic          in_rdy;
  logic          res_vld;
  logic [N*W-1:0] res_data;
  logic [2:0]    res_err;
  logic          busy;
  logic          out_vld;
  logic [W-1:0]  out_data;

  int n_chk = 0;
  int n_err = 0;

  sort_host_if #(.DATA_N(N), .DATA_W(W)) sif ();

  assign sif.sort_out_vld  = out_vld;
  assign sif.sort_out_data = out_data;

  sort_host #(.DATA_N(N), .DATA_W(W), .TIMEOUT_CYC(T)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_data (in_data),
    .in_rdy  (in_rdy),
    .sif     (sif),
    .res_vld (res_vld),
    .res_data(res_data),
    .res_err (res_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- job model ----------------
  int         pc = 0;
  bit         m_ready = 0;
  bit         m_loading;
  logic [W-1:0] m_in[$];
  logic [W-1:0] m_cap[$];
  int         m_start_idx, m_res_idx, m_win_lo, m_win_hi;
  logic [N*W-1:0] m_exp_data, m_sort_data;
  logic [2:0] m_exp_err;

  task automatic do_finish();
    logic [N*W-1:0] d;
    logic [2:0] e;
    d = '0;
    e = 3'b000;
    for (int i = 0; i < m_cap.size(); i++) d[i*W +: W] = m_cap[i];
    if (m_cap.size() == 0) e = 3'b001;
    else begin
      if (m_cap.size() < N) e[1] = 1'b1;
      for (int i = 1; i < m_cap.size(); i++)
        if (m_cap[i] < m_cap[i-1]) e[2] = 1'b1;
    end
    m_res_idx  = pc;
    m_exp_data = d;
    m_exp_err  = e;
    m_win_lo   = BIG;
  endtask

  always @(posedge clk) begin
    pc = pc + 1;
    if (rst) begin
      m_ready     = 1;
      m_loading   = 1;
      m_in.delete();
      m_cap.delete();
      m_start_idx = -1;
      m_res_idx   = -1;
      m_win_lo    = BIG;
      m_win_hi    = BIG;
      m_exp_data  = '0;
      m_exp_err   = 3'b000;
      m_sort_data = '0;
    end else if (m_ready) begin
      if (m_loading) begin
        if (in_vld) begin
          m_sort_data[m_in.size()*W +: W] = in_data;
          m_in.push_back(in_data);
          if (m_in.size() == N) begin
            m_loading   = 0;
            m_in.delete();
            m_cap.delete();
            m_start_idx = pc;
            m_win_lo    = pc + 2;
            m_win_hi    = pc + T;
          end
        end
      end else if (pc == m_res_idx + 1) begin
        m_loading = 1;
      end else if (pc >= m_win_lo) begin
        if (out_vld) begin
          m_cap.push_back(out_data);
          if (m_cap.size() == N) do_finish();
        end else if (m_cap.size() != 0 || pc == m_win_hi) begin
          do_finish();
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("in_rdy", 32'(in_rdy), 32'(m_loading));
      chk("busy", 32'(busy), 32'(!m_loading));
      chk("sort_start", 32'(sif.sort_start), 32'(pc == m_start_idx));
      chk("res_vld", 32'(res_vld), 32'(pc == m_res_idx));
      chk("res_data", 32'(res_data), 32'(m_exp_data));
      chk("res_err", 32'(res_err), 32'(m_exp_err));
      chk("sort_data", 32'(sif.sort_data), 32'(m_sort_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_rdy();
    for (int k = 0; k < 20 && !in_rdy; k++) begin
      @(posedge clk); #1;
    end
    chk("rdy_wait", 32'(in_rdy), 32'd1);
  endtask

  task automatic load_job(input logic [N*W-1:0] job, input bit gap, output int start_pc);
    wait_rdy();
    for (int i = 0; i < N; i++) begin
      in_vld  = 1'b1;
      in_data = job[i*W +: W];
      @(posedge clk); #1;
      in_vld  = 1'b0;
      if (gap && i < N - 1) begin
        chk("gap_no_start", 32'(sif.sort_start), 32'd0);
        @(posedge clk); #1;
      end
    end
    chk("start_pulse", 32'(sif.sort_start), 32'd1);
    chk("job_data", 32'(sif.sort_data), 32'(job));
    start_pc = pc;
  endtask

  task automatic sorter_send(input logic [N*W-1:0] vals, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      out_vld  = 1'b1;
      out_data = vals[i*W +: W];
      @(posedge clk); #1;
    end
    out_vld  = 1'b0;
    out_data = '0;
  endtask

  task automatic wait_res(output int idx);
    bit found;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (res_vld) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("res_seen", 32'(found), 32'd1);
    idx = pc;
  endtask

  int sp, rp;

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = '0; out_vld = 1'b0; out_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", 32'({res_vld, res_err, res_data}), 32'd0);
    rst = 1'b0;

    // 1: clean job 4,1,3,2 -> 1,2,3,4
    load_job(16'h2314, 1'b0, sp);
    sorter_send(16'h4321, N);
    wait_res(rp);
    chk("t1_lat", 32'(rp - sp), 32'd5);
    chk("t1_data", 32'(res_data), 32'h4321);
    chk("t1_err", 32'(res_err), 32'd0);

    // 2: same job with gaps on in_vld
    load_job(16'h2314, 1'b1, sp);
    sorter_send(16'h4321, N);
    wait_res(rp);
    chk("t2_data", 32'(res_data), 32'h4321);

    // 3: sorter never answers
    load_job(16'h2314, 1'b0, sp);
    wait_res(rp);
    chk("t3_lat", 32'(rp - sp), 32'd8);
    chk("t3_err", 32'(res_err), 32'd1);
    chk("t3_data", 32'(res_data), 32'd0);

    // 4: stream stops after two elements
    load_job(16'h2314, 1'b0, sp);
    sorter_send(16'h0021, 2);
    wait_res(rp);
    chk("t4_lat", 32'(rp - sp), 32'd4);
    chk("t4_err", 32'(res_err), 32'd2);
    chk("t4_data", 32'(res_data), 32'h0021);

    // 5: out-of-order stream, then a clean job
    load_job(16'h2314, 1'b0, sp);
    sorter_send(16'h4231, N);
    wait_res(rp);
    chk("t5_err", 32'(res_err), 32'd4);
    chk("t5_data", 32'(res_data), 32'h4231);
    load_job(16'h6789, 1'b0, sp);
    sorter_send(16'h9876, N);
    wait_res(rp);
    chk("t5b_err", 32'(res_err), 32'd0);
    chk("t5b_data", 32'(res_data), 32'h9876);

    // 6: reset in COLLECT after two captures, then a fresh job
    load_job(16'h5A3C, 1'b0, sp);
    @(posedge clk); #1;
    out_vld = 1'b1; out_data = 4'd1;
    @(posedge clk); #1;
    out_data = 4'd2;
    @(posedge clk); #1;
    out_data = 4'd3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_in_rdy", 32'(in_rdy), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_no_res", 32'(res_vld), 32'd0);
    rst = 1'b0; out_vld = 1'b0; out_data = '0;
    load_job(16'h0FF0, 1'b0, sp);
    sorter_send(16'hFF00, N);
    wait_res(rp);
    chk("t6_err", 32'(res_err), 32'd0);
    chk("t6_data", 32'(res_data), 32'hFF00);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
